// File: rtl/kmeans_centroid_update_k2_d2.sv
// Per-centroid sum/count accumulator for a 2-centroid, 2-dimension k-means loop.
// On epoch end, one shared restoring divider turns sum/count into new centroids.
module kmeans_centroid_update_k2_d2 #(
    parameter int input_data_width  = 16,
    parameter int centroid_id_width = 1,
    parameter int count_width       = 16,
    parameter int acc_width         = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [input_data_width-1:0]  input_data0,
    input  logic [input_data_width-1:0]  input_data1,
    input  logic [centroid_id_width-1:0] selected_centroid,
    input  logic                         epoch_done,
    input  logic                         load_valid,
    input  logic [centroid_id_width-1:0] load_id,
    input  logic [input_data_width-1:0]  load_d0,
    input  logic [input_data_width-1:0]  load_d1,
    output logic [input_data_width-1:0]  centroid0_d0,
    output logic [input_data_width-1:0]  centroid0_d1,
    output logic [input_data_width-1:0]  centroid1_d0,
    output logic [input_data_width-1:0]  centroid1_d1,
    output logic                         update_valid,
    output logic                         overflow
);

    typedef enum logic [1:0] {ACCUM, DIV, DONE} state_e;

    localparam int              IterW    = $clog2(acc_width + 1);
    localparam logic [IterW-1:0] LastIter = IterW'(acc_width);

    state_e                      state_q, state_d;
    logic [acc_width-1:0]        sum_q      [2][2];
    logic [acc_width-1:0]        sum_d      [2][2];
    logic [count_width-1:0]      count_q    [2];
    logic [count_width-1:0]      count_d    [2];
    logic [input_data_width-1:0] centroid_q [2][2];
    logic [input_data_width-1:0] centroid_d [2][2];
    logic                        overflow_q, overflow_d;
    logic [1:0]                  slot_q, slot_d;
    logic [IterW-1:0]            iter_q, iter_d;
    logic [count_width-1:0]      rem_q, rem_d;
    logic [acc_width-1:0]        dvd_q, dvd_d;

    logic                        sample_id;
    logic                        wr_id;
    logic [count_width-1:0]      divisor;
    logic [count_width:0]        rem_shift;
    logic [count_width:0]        rem_sub;
    logic                        quo_bit;
    logic [acc_width-1:0]        dvd_next;

    assign sample_id = selected_centroid[0];
    assign wr_id     = load_id[0];

    // Divider datapath: dvd_q shifts the dividend out at the top while
    // quotient bits enter at the bottom, so it holds the quotient at the end.
    assign divisor   = count_q[slot_q[1]];
    assign rem_shift = {rem_q, dvd_q[acc_width-1]};
    assign quo_bit   = (rem_shift >= {1'b0, divisor});
    assign rem_sub   = quo_bit ? (rem_shift - {1'b0, divisor}) : rem_shift;
    assign dvd_next  = {dvd_q[acc_width-2:0], quo_bit};

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through this block infers a latch.
        state_d    = state_q;
        sum_d      = sum_q;
        count_d    = count_q;
        centroid_d = centroid_q;
        overflow_d = overflow_q;
        slot_d     = slot_q;
        iter_d     = iter_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (count_q[sample_id] == {count_width{1'b1}}) begin
                        overflow_d = 1'b1;
                    end else begin
                        sum_d[sample_id][0] = sum_q[sample_id][0] + acc_width'(input_data0);
                        sum_d[sample_id][1] = sum_q[sample_id][1] + acc_width'(input_data1);
                        count_d[sample_id]  = count_q[sample_id] + 1'b1;
                    end
                end
                if (load_valid) begin
                    centroid_d[wr_id][0] = load_d0;
                    centroid_d[wr_id][1] = load_d1;
                end
                if (epoch_done) begin
                    state_d = DIV;
                    slot_d  = 2'd0;
                    iter_d  = '0;
                end
            end

            DIV: begin
                if (iter_q == '0) begin
                    dvd_d  = sum_q[slot_q[1]][slot_q[0]];
                    rem_d  = '0;
                    iter_d = IterW'(1);
                end else begin
                    dvd_d = dvd_next;
                    rem_d = rem_sub[count_width-1:0];
                    if (iter_q == LastIter) begin
                        // Empty cluster keeps its centroid; the slot length stays fixed.
                        if (divisor != '0) begin
                            centroid_d[slot_q[1]][slot_q[0]] = dvd_next[input_data_width-1:0];
                        end
                        iter_d = '0;
                        if (slot_q == 2'd3) begin
                            state_d = DONE;
                        end else begin
                            slot_d = slot_q + 2'd1;
                        end
                    end else begin
                        iter_d = iter_q + 1'b1;
                    end
                end
            end

            DONE: begin
                sum_d      = '{default: '0};
                count_d    = '{default: '0};
                overflow_d = 1'b0;
                state_d    = ACCUM;
            end

            default: state_d = ACCUM;
        endcase
    end

    // NOTE: non-blocking assignments let every register update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sums and counts are reset explicitly; an empty cluster must read count 0, not X.
            state_q    <= ACCUM;
            sum_q      <= '{default: '0};
            count_q    <= '{default: '0};
            centroid_q <= '{default: '0};
            overflow_q <= 1'b0;
            slot_q     <= 2'd0;
            iter_q     <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            count_q    <= count_d;
            centroid_q <= centroid_d;
            overflow_q <= overflow_d;
            slot_q     <= slot_d;
            iter_q     <= iter_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
        end
    end

    assign in_ready     = (state_q == ACCUM);
    assign update_valid = (state_q == DONE);
    assign overflow     = overflow_q;
    assign centroid0_d0 = centroid_q[0][0];
    assign centroid0_d1 = centroid_q[0][1];
    assign centroid1_d0 = centroid_q[1][0];
    assign centroid1_d1 = centroid_q[1][1];

endmodule

// File: tb/tb_kmeans_centroid_update_k2_d2.sv
// Bench for the k-means centroid updater: a 16-bit-count build and a 2-bit-count build
// share one stimulus stream and are compared against a mean-of-members model.
module tb_kmeans_centroid_update_k2_d2;

    localparam int EpochLatency = 133;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, epoch_done, load_valid;
    logic        sel, load_id;
    logic [15:0] x0, x1, l0, l1;

    logic [15:0] a_c00, a_c01, a_c10, a_c11, b_c00, b_c01, b_c10, b_c11;
    logic        a_rdy, a_upd, a_ovf, b_rdy, b_upd, b_ovf;

    int          checks = 0;
    int          errors = 0;

    int unsigned m_sum [2][2][2];
    int unsigned m_cnt [2][2];
    logic [15:0] m_cen [2][2][2];
    logic        m_ovf [2];
    int unsigned cmax  [2] = '{65535, 3};

    always #5 clk = ~clk;

    kmeans_centroid_update_k2_d2 #(.count_width(16), .acc_width(32)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy),
        .input_data0(x0), .input_data1(x1), .selected_centroid(sel),
        .epoch_done(epoch_done), .load_valid(load_valid), .load_id(load_id),
        .load_d0(l0), .load_d1(l1),
        .centroid0_d0(a_c00), .centroid0_d1(a_c01), .centroid1_d0(a_c10), .centroid1_d1(a_c11),
        .update_valid(a_upd), .overflow(a_ovf)
    );

    kmeans_centroid_update_k2_d2 #(.count_width(2), .acc_width(32)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_rdy),
        .input_data0(x0), .input_data1(x1), .selected_centroid(sel),
        .epoch_done(epoch_done), .load_valid(load_valid), .load_id(load_id),
        .load_d0(l0), .load_d1(l1),
        .centroid0_d0(b_c00), .centroid0_d1(b_c01), .centroid1_d0(b_c10), .centroid1_d1(b_c11),
        .update_valid(b_upd), .overflow(b_ovf)
    );

    function automatic logic [15:0] cen_of(input int u, input int k, input int d);
        case ({u[0], k[0], d[0]})
            3'b000: return a_c00;
            3'b001: return a_c01;
            3'b010: return a_c10;
            3'b011: return a_c11;
            3'b100: return b_c00;
            3'b101: return b_c01;
            3'b110: return b_c10;
            default: return b_c11;
        endcase
    endfunction

    function automatic logic rdy_of(input int u);
        return (u == 0) ? a_rdy : b_rdy;
    endfunction

    function automatic logic upd_of(input int u);
        return (u == 0) ? a_upd : b_upd;
    endfunction

    function automatic logic ovf_of(input int u);
        return (u == 0) ? a_ovf : b_ovf;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        epoch_done = 1'b0;
        load_valid = 1'b0;
        sel        = 1'b0;
        load_id    = 1'b0;
        x0 = '0; x1 = '0; l0 = '0; l1 = '0;
    endtask

    task automatic junk_inputs();
        in_valid   = 1'($urandom);
        epoch_done = 1'($urandom);
        load_valid = 1'($urandom);
        sel        = 1'($urandom);
        load_id    = 1'($urandom);
        x0 = 16'($urandom); x1 = 16'($urandom);
        l0 = 16'($urandom); l1 = 16'($urandom);
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_ovf[u] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_cnt[u][k] = 0;
                for (int d = 0; d < 2; d++) begin
                    m_sum[u][k][d] = 0;
                    m_cen[u][k][d] = '0;
                end
            end
        end
    endtask

    // New centroid = floor(mean of accepted members); an empty cluster keeps its value.
    task automatic model_epoch();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 2; k++) begin
                for (int d = 0; d < 2; d++) begin
                    if (m_cnt[u][k] != 0) m_cen[u][k][d] = 16'(m_sum[u][k][d] / m_cnt[u][k]);
                    m_sum[u][k][d] = 0;
                end
                m_cnt[u][k] = 0;
            end
            m_ovf[u] = 1'b0;
        end
    endtask

    // One accepting cycle in the accumulate phase: optional sample, optional load, optional epoch.
    task automatic do_cycle(input logic v, input logic id, input logic [15:0] a, input logic [15:0] b,
                            input logic ld, input logic lid, input logic [15:0] la, input logic [15:0] lb,
                            input logic ep);
        in_valid = v; sel = id; x0 = a; x1 = b;
        load_valid = ld; load_id = lid; l0 = la; l1 = lb;
        epoch_done = ep;
        tick();
        idle_inputs();
        for (int u = 0; u < 2; u++) begin
            if (v) begin
                if (m_cnt[u][id] == cmax[u]) begin
                    m_ovf[u] = 1'b1;
                end else begin
                    m_sum[u][id][0] += a;
                    m_sum[u][id][1] += b;
                    m_cnt[u][id]++;
                end
            end
            if (ld) begin
                m_cen[u][lid][0] = la;
                m_cen[u][lid][1] = lb;
            end
        end
    endtask

    task automatic sample(input logic id, input int a, input int b);
        do_cycle(1'b1, id, 16'(a), 16'(b), 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic load(input logic id, input int a, input int b);
        do_cycle(1'b0, 1'b0, '0, '0, 1'b1, id, 16'(a), 16'(b), 1'b0);
    endtask

    task automatic check_state(input string tag);
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 2; k++)
                for (int d = 0; d < 2; d++)
                    check($sformatf("%s.u%0d.c%0d_d%0d", tag, u, k, d), 32'(cen_of(u, k, d)), 32'(m_cen[u][k][d]));
            check($sformatf("%s.u%0d.overflow", tag, u), 32'(ovf_of(u)), 32'(m_ovf[u]));
            check($sformatf("%s.u%0d.in_ready", tag, u), 32'(rdy_of(u)), 32'd1);
            check($sformatf("%s.u%0d.update_valid", tag, u), 32'(upd_of(u)), 32'd0);
        end
    endtask

    // Epoch strobe (optionally with a final sample), junk offered during the division phase,
    // latency measured to the update pulse, then results and the return to accumulate checked.
    task automatic run_epoch(input string tag, input logic v, input logic id, input int a, input int b);
        int n;
        do_cycle(v, id, 16'(a), 16'(b), 1'b0, 1'b0, '0, '0, 1'b1);
        n = 1;
        check({tag, ".busy_a"}, 32'(a_rdy), 32'd0);
        check({tag, ".busy_b"}, 32'(b_rdy), 32'd0);
        while (a_upd !== 1'b1 && n < 200) begin
            junk_inputs();
            tick();
            n++;
        end
        idle_inputs();
        check({tag, ".latency"}, 32'(n), 32'(EpochLatency));
        check({tag, ".upd_b"}, 32'(b_upd), 32'd1);
        model_epoch();
        for (int u = 0; u < 2; u++)
            for (int k = 0; k < 2; k++)
                for (int d = 0; d < 2; d++)
                    check($sformatf("%s.done.u%0d.c%0d_d%0d", tag, u, k, d), 32'(cen_of(u, k, d)), 32'(m_cen[u][k][d]));
        tick();
        check_state({tag, ".after"});
    endtask

    initial begin
        int  n;
        logic seen;
        idle_inputs();
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_state("reset");

        load(1'b0, 100, 200);
        load(1'b1, 5, 6);
        check_state("load");

        sample(1'b0, 10, 20);
        sample(1'b0, 30, 40);
        sample(1'b1, 7, 9);
        check_state("accum");
        run_epoch("basic", 1'b0, 1'b0, 0, 0);

        sample(1'b0, 1, 3);
        sample(1'b0, 2, 4);
        load(1'b1, 55, 66);
        run_epoch("trunc_empty", 1'b0, 1'b0, 0, 0);

        run_epoch("with_sample", 1'b1, 1'b1, 50, 60);
        run_epoch("no_samples", 1'b0, 1'b0, 0, 0);

        sample(1'b0, 10, 1);
        sample(1'b0, 20, 2);
        sample(1'b0, 30, 3);
        sample(1'b0, 40, 4);
        check_state("saturate");
        run_epoch("saturate", 1'b0, 1'b0, 0, 0);

        for (int e = 0; e < 6; e++) begin
            int ns;
            ns = int'($urandom_range(0, 8));
            for (int s = 0; s < ns; s++) begin
                do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom), 16'($urandom),
                         1'($urandom_range(0, 3) == 0), 1'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            end
            check_state($sformatf("rand%0d", e));
            run_epoch($sformatf("rand%0d", e), 1'($urandom), 1'($urandom), int'($urandom_range(0, 65535)),
                      int'($urandom_range(0, 65535)));
        end

        sample(1'b0, 900, 800);
        sample(1'b1, 700, 600);
        do_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        for (n = 1; n < 50; n++) begin
            junk_inputs();
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_state("mid_div_reset");
        seen = 1'b0;
        for (int c = 0; c < 150; c++) begin
            seen = seen | a_upd | b_upd;
            tick();
        end
        check("mid_div_reset.no_update", 32'(seen), 32'd0);
        check_state("mid_div_reset.idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
